// File: rtl/pwm_ramp_pkg.sv
// Shared types and step arithmetic for the pwmout ramp sequencer.
package pwm_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam int DTY_W  = 32;
    localparam int DIFF_W = DTY_W + 1;

    typedef logic signed [DTY_W-1:0]  dty_t;
    typedef logic signed [DIFF_W-1:0] diff_t;

    function automatic logic signed [1:0] sign_of(input diff_t v);
        if (v[DIFF_W-1])
            return -2'sd1;
        else if (v != '0)
            return 2'sd1;
        else
            return 2'sd0;
    endfunction

    // Move cur toward dst by at most step; the difference is taken one bit wider so it cannot overflow.
    function automatic dty_t step_toward(input dty_t cur, input dty_t dst, input diff_t step);
        diff_t            d;
        diff_t            mag;
        diff_t            lim;
        diff_t            res;
        logic signed [1:0] s;
        d   = diff_t'({dst[DTY_W-1], dst}) - diff_t'({cur[DTY_W-1], cur});
        mag = d[DIFF_W-1] ? -d : d;
        lim = (mag > step) ? step : mag;
        s   = sign_of(d);
        if (s == 2'sd1)
            res = diff_t'({cur[DTY_W-1], cur}) + lim;
        else if (s == -2'sd1)
            res = diff_t'({cur[DTY_W-1], cur}) - lim;
        else
            res = diff_t'({cur[DTY_W-1], cur});
        return dty_t'(res[DTY_W-1:0]);
    endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running PWM period counter; tick is high for the one clk where the count equals DIVIDER.
module pwm_period_tick #(
    parameter int DIVIDER = 255
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIVIDER > 0) ? $clog2(DIVIDER + 1) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIVIDER));

    // NOTE: non-blocking assignments for every register so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pwmout_ramp_ctrl.sv
// Slew-limiting duty sequencer in front of one pwmout channel.
// Optional setpoint watchdog enabled by defining PWM_RAMP_WATCHDOG_EN.
module pwmout_ramp_ctrl
    import pwm_ramp_pkg::*;
#(
    parameter int DIVIDER          = 255,
    parameter int STEP             = 4,
    parameter int DTY_MAX          = 255,
    parameter int DEADTIME_PERIODS = 2,
    parameter int WDT_CYCLES       = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [31:0] set_dty,
    input  logic               set_valid,
    input  logic               enable_in,
    output logic signed [31:0] dty_out,
    output logic               enable_out,
    output logic               at_target,
    output logic               busy,
    output logic               fault
);

    localparam diff_t STEP_D = diff_t'(STEP);
    localparam dty_t  DMAX   = dty_t'(DTY_MAX);

    state_t      state;
    state_t      state_next;
    dty_t        dty_q;
    dty_t        dty_next;
    dty_t        target;
    dty_t        set_clamped;
    logic        rev_pend;
    logic        rev_pend_next;
    logic [31:0] dead_cnt;
    logic [31:0] dead_cnt_next;
    logic        tick;
    logic        reversal;
    logic        wdt_hit;

    pwm_period_tick #(.DIVIDER(DIVIDER)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        if (set_dty > DMAX)
            set_clamped = DMAX;
        else if (set_dty < -DMAX)
            set_clamped = -DMAX;
        else
            set_clamped = set_dty;
    end

    // A setpoint arriving on a tick edge lands after that tick's step, which still uses the old target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            target <= '0;
        else if (set_valid)
            target <= set_clamped;
        else if (wdt_hit)
            target <= '0;
    end

`ifdef PWM_RAMP_WATCHDOG_EN
    logic [31:0] wdt_cnt;
    logic        fault_q;

    assign wdt_hit = !set_valid && (state != IDLE) && (wdt_cnt == 32'(WDT_CYCLES - 1));
    assign fault   = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt <= '0;
            fault_q <= 1'b0;
        end else if (set_valid) begin
            wdt_cnt <= '0;
            fault_q <= 1'b0;
        end else if (wdt_hit) begin
            wdt_cnt <= wdt_cnt + 32'd1;
            fault_q <= 1'b1;
        end else if ((state != IDLE) && (wdt_cnt < 32'(WDT_CYCLES))) begin
            wdt_cnt <= wdt_cnt + 32'd1;
        end
    end
`else
    logic unused_wdt;

    assign wdt_hit    = 1'b0;
    assign fault      = 1'b0;
    assign unused_wdt = ^32'(WDT_CYCLES);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dty_q    <= '0;
            rev_pend <= 1'b0;
            dead_cnt <= '0;
        end else begin
            state    <= state_next;
            dty_q    <= dty_next;
            rev_pend <= rev_pend_next;
            dead_cnt <= dead_cnt_next;
        end
    end

    assign reversal = ((dty_q > 0) && (target < 0)) || ((dty_q < 0) && (target > 0));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_next    = state;
        dty_next      = dty_q;
        rev_pend_next = rev_pend;
        dead_cnt_next = dead_cnt;
        case (state)
            IDLE: begin
                dty_next      = '0;
                rev_pend_next = 1'b0;
                dead_cnt_next = '0;
                if (enable_in)
                    state_next = RUN;
            end
            RUN: begin
                if (!enable_in) begin
                    state_next = STOP;
                end else if (tick) begin
                    if (reversal) begin
                        dty_next      = step_toward(dty_q, '0, STEP_D);
                        rev_pend_next = 1'b1;
                    end else if ((dty_q == '0) && rev_pend) begin
                        rev_pend_next = 1'b0;
                        if (DEADTIME_PERIODS == 0) begin
                            dty_next = step_toward(dty_q, target, STEP_D);
                        end else begin
                            state_next    = DEAD;
                            dead_cnt_next = '0;
                        end
                    end else begin
                        dty_next = step_toward(dty_q, target, STEP_D);
                    end
                end
            end
            DEAD: begin
                if (!enable_in) begin
                    state_next = IDLE;
                end else if (tick) begin
                    if (dead_cnt + 32'd1 >= 32'(DEADTIME_PERIODS)) begin
                        state_next    = RUN;
                        dead_cnt_next = '0;
                    end else begin
                        dead_cnt_next = dead_cnt + 32'd1;
                    end
                end
            end
            STOP: begin
                if (enable_in) begin
                    state_next = RUN;
                end else if (tick) begin
                    dty_next = step_toward(dty_q, '0, STEP_D);
                    if (dty_next == '0)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dty_out    = dty_q;
        enable_out = (state != IDLE);
        at_target  = (state == RUN) && (dty_q == target);
        busy       = (state != IDLE) && !at_target;
    end

endmodule

// File: tb/tb_pwmout_ramp_ctrl.sv
// Directed bench for pwmout_ramp_ctrl; the watchdog scenario runs when PWM_RAMP_WATCHDOG_EN is defined.
module tb_pwmout_ramp_ctrl;

    localparam int DIVIDER          = 3;
    localparam int STEP             = 4;
    localparam int DTY_MAX          = 20;
    localparam int DEADTIME_PERIODS = 2;
    localparam int WDT_CYCLES       = 50;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [31:0] set_dty;
    logic               set_valid;
    logic               enable_in;
    logic signed [31:0] dty_out;
    logic               enable_out;
    logic               at_target;
    logic               busy;
    logic               fault;

    int n_checks = 0;
    int n_fails  = 0;
    int ph;

    always #5 clk = ~clk;

    pwmout_ramp_ctrl #(
        .DIVIDER          (DIVIDER),
        .STEP             (STEP),
        .DTY_MAX          (DTY_MAX),
        .DEADTIME_PERIODS (DEADTIME_PERIODS),
        .WDT_CYCLES       (WDT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_dty    (set_dty),
        .set_valid  (set_valid),
        .enable_in  (enable_in),
        .dty_out    (dty_out),
        .enable_out (enable_out),
        .at_target  (at_target),
        .busy       (busy),
        .fault      (fault)
    );

    // Bench-side model of the period phase; ph returns to 0 right after a tick edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ph <= 0;
        else
            ph <= (ph == DIVIDER) ? 0 : ph + 1;
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_edge();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (ph != 0 && guard < 2 * (DIVIDER + 1));
    endtask

    task automatic ticks(input int n);
        repeat (n) tick_edge();
    endtask

    task automatic set_target(input logic signed [31:0] v);
        set_dty   = v;
        set_valid = 1'b1;
        @(negedge clk);
        set_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        set_dty   = '0;
        set_valid = 1'b0;
        enable_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dty", dty_out, 0);
        check("rst_en", enable_out, 0);
        check("rst_at_target", at_target, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        rst_n = 1'b1;

        // Enable and ramp up to +10
        enable_in = 1'b1;
        set_target(10);
        check("en_edge_en", enable_out, 1);
        check("en_edge_dty", dty_out, 0);
        check("en_edge_busy", busy, 1);
        tick_edge(); check("up_t1", dty_out, 4);
        tick_edge(); check("up_t2", dty_out, 8);
        check("up_t2_at", at_target, 0);
        tick_edge(); check("up_t3", dty_out, 10);
        check("up_at_target", at_target, 1);
        check("up_busy", busy, 0);

        // Reversal through zero with dead-time
        set_target(-6);
        check("rev_at_target", at_target, 0);
        tick_edge(); check("rev_t1", dty_out, 6);
        tick_edge(); check("rev_t2", dty_out, 2);
        tick_edge(); check("rev_t3", dty_out, 0);
        tick_edge(); check("dead_t1", dty_out, 0);
        tick_edge(); check("dead_t2", dty_out, 0);
        check("dead_busy", busy, 1);
        tick_edge(); check("dead_t3", dty_out, 0);
        tick_edge(); check("rev_t4", dty_out, -4);
        tick_edge(); check("rev_t5", dty_out, -6);
        check("rev_at_target_end", at_target, 1);
        check("rev_en", enable_out, 1);

        // Clamp and setpoint landing on a tick edge
        for (int g = 0; g < 8 && ph != DIVIDER; g++) @(negedge clk);
        set_target(50);
        check("tickset_old_target", dty_out, -6);
        tick_edge(); check("clamp_t1", dty_out, -2);
        tick_edge(); check("clamp_t2", dty_out, 0);
        ticks(3);    check("clamp_dead_end", dty_out, 0);
        tick_edge(); check("clamp_t6", dty_out, 4);
        ticks(4);    check("clamp_t10", dty_out, 20);
        check("clamp_at_target", at_target, 1);
        tick_edge(); check("clamp_hold", dty_out, 20);

        // Disable ramp-down, re-enable mid-ramp, then full stop
        set_target(10);
        ticks(3);    check("down_to_10", dty_out, 10);
        enable_in = 1'b0;
        @(negedge clk);
        check("stop_en", enable_out, 1);
        check("stop_busy", busy, 1);
        check("stop_no_step", dty_out, 10);
        tick_edge(); check("stop_t1", dty_out, 6);
        enable_in = 1'b1;
        @(negedge clk);
        check("reen_dty", dty_out, 6);
        tick_edge(); check("reen_t1", dty_out, 10);
        check("reen_at_target", at_target, 1);
        enable_in = 1'b0;
        tick_edge(); check("stop2_t1", dty_out, 6);
        tick_edge(); check("stop2_t2", dty_out, 2);
        check("stop2_t2_en", enable_out, 1);
        tick_edge(); check("stop2_t3", dty_out, 0);
        check("stop2_en_off", enable_out, 0);
        check("stop2_busy", busy, 0);

        // Setpoint 0 while running: plain ramp down, channel stays enabled
        enable_in = 1'b1;
        set_target(4);
        tick_edge(); check("zero_up", dty_out, 4);
        set_target(0);
        tick_edge(); check("zero_dty", dty_out, 0);
        check("zero_en", enable_out, 1);
        check("zero_at_target", at_target, 1);

        // Asynchronous reset in the middle of a ramp
        set_target(20);
        tick_edge(); check("mid_t1", dty_out, 4);
        tick_edge(); check("mid_t2", dty_out, 8);
        rst_n = 1'b0;
        #1;
        check("arst_dty", dty_out, 0);
        check("arst_en", enable_out, 0);
        check("arst_at_target", at_target, 0);
        check("arst_busy", busy, 0);
        check("arst_fault", fault, 0);
        enable_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_dty", dty_out, 0);
        check("post_rst_en", enable_out, 0);
        check("post_rst_busy", busy, 0);
        tick_edge();

        // Setpoint watchdog
        enable_in = 1'b1;
        set_target(8);
`ifdef PWM_RAMP_WATCHDOG_EN
        repeat (WDT_CYCLES - 1) @(negedge clk);
        check("wdt_before", fault, 0);
        @(negedge clk);
        check("wdt_fault", fault, 1);
        check("wdt_dty_at_fault", dty_out, 8);
        tick_edge(); check("wdt_ramp_t1", dty_out, 4);
        tick_edge(); check("wdt_ramp_t2", dty_out, 0);
        check("wdt_en_kept", enable_out, 1);
        check("wdt_fault_sticky", fault, 1);
        set_target(8);
        check("wdt_clear", fault, 0);
        tick_edge(); check("wdt_resume", dty_out, 4);
`else
        repeat (WDT_CYCLES + 10) @(negedge clk);
        check("nowdt_fault", fault, 0);
        check("nowdt_dty", dty_out, 8);
        check("nowdt_en", enable_out, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
